// File: rtl/br_pkg.sv
// ============================================================================
//  Module  : br_pkg
//  Brief   : Shared types and constants for the branch resolution slice.
//            The prediction record is stored at the widest supported address
//            width; blocks zero-extend narrower addresses into it.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package br_pkg;

    // Widest address the record can carry; XLEN of any user must not exceed it.
    localparam int unsigned c_XLEN_MAX = 64;

    // Sequential-fetch increment used for the not-taken redirect address.
    localparam int unsigned c_PC_INC = 4;

    // One in-flight prediction: direction, branch address, predicted target.
    typedef struct packed {
        logic                  taken;
        logic [c_XLEN_MAX-1:0] pc;
        logic [c_XLEN_MAX-1:0] target;
    } pred_rec_t;

    // Fall-through address of a branch (caller truncates to its XLEN).
    function automatic logic [c_XLEN_MAX-1:0] seq_pc(input logic [c_XLEN_MAX-1:0] pc);
        return pc + c_XLEN_MAX'(c_PC_INC);
    endfunction

endpackage

`default_nettype wire

// File: rtl/br_resolve_if.sv
// ============================================================================
//  Module  : br_resolve_if
//  Brief   : Fetch/execute facing bundle of the branch resolver. The master
//            side offers predictions and resolutions; the slave side is the
//            resolver. Statistics signals exist only with BR_RESOLVE_STATS_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface br_resolve_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    // Prediction record from fetch
    logic                       pred_valid;
    logic                       pred_ready;
    logic                       pred_taken;
    logic [XLEN-1:0]            pred_pc;
    logic [XLEN-1:0]            pred_target;
    // Resolution from execute
    logic                       res_valid;
    logic                       res_taken;
    logic [XLEN-1:0]            res_target;
    // Redirect / training / status
    logic                       branch_flag;
    logic [XLEN-1:0]            branch_addr;
    logic                       branch_pre_re;
    logic                       res_done;
    logic [$clog2(DEPTH):0]     count;
    logic                       err_underflow;
`ifdef BR_RESOLVE_STATS_EN
    logic [31:0]                stat_branches;
    logic [31:0]                stat_mispred;
`endif

    modport master (
        output pred_valid, pred_taken, pred_pc, pred_target,
        output res_valid, res_taken, res_target,
`ifdef BR_RESOLVE_STATS_EN
        input  stat_branches, stat_mispred,
`endif
        input  pred_ready, branch_flag, branch_addr, branch_pre_re,
        input  res_done, count, err_underflow
    );

    modport slave (
        input  pred_valid, pred_taken, pred_pc, pred_target,
        input  res_valid, res_taken, res_target,
`ifdef BR_RESOLVE_STATS_EN
        output stat_branches, stat_mispred,
`endif
        output pred_ready, branch_flag, branch_addr, branch_pre_re,
        output res_done, count, err_underflow
    );

endinterface

`default_nettype wire

// File: rtl/br_pred_fifo.sv
// ============================================================================
//  Module  : br_pred_fifo
//  Brief   : In-flight prediction queue. Push at tail, pop at head, flush
//            empties it in one edge and wins over a same-cycle push.
//            DEPTH must be a power of two so pointers wrap naturally.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module br_pred_fifo
    import br_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push_i,
    input  wire pred_rec_t              rec_i,
    input  wire logic                   pop_i,
    input  wire logic                   flush_i,
    output pred_rec_t                   head_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    pred_rec_t              mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q,  count_d;
    logic                   w_push;
    logic                   w_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Guard against overfill / underflow even if the caller does not.
    assign w_push = push_i & ~full_o & ~flush_i;
    assign w_pop  = pop_i  & ~empty_o & ~flush_i;

    // Next pointer/occupancy; flush discards everything including a push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Record storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_q[wr_ptr_q] <= rec_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/br_resolve.sv
// ============================================================================
//  Module  : br_resolve
//  Brief   : Branch resolution unit. Queues fetch-time predictions, compares
//            the oldest against execute's outcome, and one cycle later either
//            redirects fetch (mispredict, queue flushed) or signals a correct
//            prediction for training. Optional counters: BR_RESOLVE_STATS_EN.
//            XLEN may range up to br_pkg::c_XLEN_MAX.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module br_resolve
    import br_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    br_resolve_if.slave bus
);

    pred_rec_t              w_push_rec;
    pred_rec_t              w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_res_accept;
    logic                   w_mispredict;
    logic                   w_flush;
    logic [c_XLEN_MAX-1:0]  w_res_target_ext;
    logic [c_XLEN_MAX-1:0]  w_seq_pc_full;
    logic                   w_unused_seq_hi;

    logic                   branch_flag_q,   branch_flag_d;
    logic [XLEN-1:0]        branch_addr_q,   branch_addr_d;
    logic                   branch_pre_re_q, branch_pre_re_d;
    logic                   res_done_q,      res_done_d;
    logic                   err_underflow_q, err_underflow_d;

    // Ready depends on occupancy only, never on a same-cycle resolution.
    assign bus.pred_ready = ~w_full;
    assign w_push         = bus.pred_valid & ~w_full;

    assign w_push_rec.taken  = bus.pred_taken;
    assign w_push_rec.pc     = c_XLEN_MAX'(bus.pred_pc);
    assign w_push_rec.target = c_XLEN_MAX'(bus.pred_target);

    assign w_res_target_ext = c_XLEN_MAX'(bus.res_target);

    // A resolution against an empty queue is ignored apart from the error flag.
    assign w_res_accept = bus.res_valid & ~w_empty;

    assign w_mispredict = (w_head.taken != bus.res_taken) ||
                          (w_head.taken && bus.res_taken && (w_head.target != w_res_target_ext));

    assign w_flush = w_res_accept & w_mispredict;

    // Fall-through address; only the low XLEN bits matter so it wraps at XLEN.
    assign w_seq_pc_full   = seq_pc(w_head.pc);
    assign w_unused_seq_hi = ^w_seq_pc_full;

    br_pred_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .rec_i   (w_push_rec),
        .pop_i   (w_res_accept),
        .flush_i (w_flush),
        .head_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Compute the one-cycle-later outcome pulses and redirect address.
    always_comb begin
        branch_flag_d   = 1'b0;
        branch_addr_d   = '0;
        branch_pre_re_d = 1'b0;
        res_done_d      = w_res_accept;
        err_underflow_d = err_underflow_q | (bus.res_valid & w_empty);
        if (w_res_accept) begin
            if (w_mispredict) begin
                branch_flag_d = 1'b1;
                branch_addr_d = bus.res_taken ? bus.res_target : w_seq_pc_full[XLEN-1:0];
            end else begin
                branch_pre_re_d = 1'b1;
            end
        end
    end

    // Registered outcome outputs and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_flag_q   <= 1'b0;
            branch_addr_q   <= '0;
            branch_pre_re_q <= 1'b0;
            res_done_q      <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            branch_flag_q   <= branch_flag_d;
            branch_addr_q   <= branch_addr_d;
            branch_pre_re_q <= branch_pre_re_d;
            res_done_q      <= res_done_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign bus.branch_flag   = branch_flag_q;
    assign bus.branch_addr   = branch_addr_q;
    assign bus.branch_pre_re = branch_pre_re_q;
    assign bus.res_done      = res_done_q;
    assign bus.count         = w_count;
    assign bus.err_underflow = err_underflow_q;

`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispred_q;

    // Saturating counters of accepted resolutions and mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (w_res_accept && (stat_branches_q != '1)) stat_branches_q <= stat_branches_q + 1'b1;
            if (w_flush && (stat_mispred_q != '1))       stat_mispred_q  <= stat_mispred_q + 1'b1;
        end
    end

    assign bus.stat_branches = stat_branches_q;
    assign bus.stat_mispred  = stat_mispred_q;
`endif

endmodule

`default_nettype wire

// File: doc/br_resolve.md
BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the in-flight prediction queue entries (power of two, 2..16).
REQ-002 Parameter XLEN, default 32, SHALL set the address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 pred_valid  input  1  SHALL mark a prediction record offered by the fetch stage.
REQ-006 pred_ready  output  1  SHALL accept the record when high together with pred_valid.
REQ-007 pred_taken  input  1  SHALL be the predicted direction.
REQ-008 pred_pc  input  XLEN  SHALL be the branch instruction address.
REQ-009 pred_target  input  XLEN  SHALL be the predicted target.
REQ-010 res_valid  input  1  SHALL mark that execute resolved the oldest outstanding branch.
REQ-011 res_taken  input  1  SHALL be the actual direction.
REQ-012 res_target  input  XLEN  SHALL be the actual target.
REQ-013 branch_flag  output  1  SHALL pulse one cycle to redirect fetch.
REQ-014 branch_addr  output  XLEN  SHALL be the redirect address, valid while branch_flag is high.
REQ-015 branch_pre_re  output  1  SHALL pulse one cycle when a resolved prediction was correct (feeds predictor training).
REQ-016 res_done  output  1  SHALL pulse one cycle for every accepted resolution.
REQ-017 count  output  $clog2(DEPTH)+1  SHALL report queue occupancy.
REQ-018 err_underflow  output  1  SHALL be a sticky flag for resolution against an empty queue.

Function
REQ-019 pred_ready SHALL equal (count != DEPTH) and SHALL not depend on res_valid.
REQ-020 An accepted record SHALL be written at the tail; a resolution SHALL consume the head (FIFO order, pointers wrap modulo DEPTH).
REQ-021 A mispredict SHALL be: pred_taken != res_taken, or both taken and pred_target != res_target.
REQ-022 Outputs branch_flag, branch_addr, branch_pre_re, res_done SHALL be registered, asserted exactly one cycle after the res_valid cycle.
REQ-023 On mispredict: branch_flag=1; branch_addr = res_target if res_taken, else head.pc+4 (XLEN wrap); branch_pre_re=0.
REQ-024 On correct prediction: branch_flag=0, branch_pre_re=1.
REQ-025 On mispredict the whole queue SHALL be flushed (count=0) at the same edge; a push in that same cycle SHALL be discarded.
REQ-026 Push and correct resolution in one cycle SHALL leave count unchanged; at count==DEPTH push SHALL not be accepted even if a pop occurs.
REQ-027 res_valid with count==0 SHALL be ignored (no pulses), and SHALL set err_underflow until reset.

Reset
REQ-028 With rst high at a clock edge: pointers and count=0, branch_flag=0, branch_addr=0, branch_pre_re=0, res_done=0, err_underflow=0; queue contents need not clear.
REQ-029 rst SHALL override a same-cycle push or resolution; in-flight records are dropped.

Configuration
REQ-030 Macro BR_RESOLVE_STATS_EN defined: outputs stat_branches and stat_mispred (32-bit, saturating at all-ones) SHALL count accepted resolutions and mispredicts, cleared by rst.
REQ-031 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-032 Shared package br_pkg SHALL hold the prediction-record typedef (taken, pc, target) and the PC increment constant 4.
REQ-033 The queue SHALL be a sub-module br_pred_fifo (push/pop/flush, count); compare/redirect logic stays in br_resolve.

Verification
REQ-034 Reset then push {taken=1,pc=0x100,target=0x200}, resolve taken/0x200 -> next cycle branch_pre_re=1, res_done=1, branch_flag=0, count=0.
REQ-035 Push {taken=0,pc=0x100}, resolve taken/0x180 -> branch_flag=1, branch_addr=0x180; push {taken=1,pc=0x7FC}, resolve not-taken -> branch_addr=0x800.
REQ-036 Push 4 records (DEPTH=4) -> pred_ready=0, count=4; fifth push with simultaneous correct resolve -> not accepted, count=3.
REQ-037 Three queued, oldest mispredicts while pushing -> count=0 next cycle, pushed record lost, branch_flag=1.
REQ-038 res_valid with empty queue -> no pulses, err_underflow=1 stays until rst; rst asserted mid-stream with count=2 -> count=0, all outputs 0.
REQ-039 With BR_RESOLVE_STATS_EN: 5 resolutions, 2 mispredicts -> stat_branches=5, stat_mispred=2.
